// File: rtl/darkio_arb_pkg.sv
// -----------------------------------------------------------------------------
// darkio_arb_pkg
// Shared definitions for the two-master darkio X-bus arbiter.
//   state_e          : arbiter state encoding (ST_IDLE=0, ST_BUSY=1)
//   DARKIO_ERR_DATA  : read data the debug master substitutes when MERR is set
//   pick32 / pick4   : select master i's field out of a packed per-master bus
// -----------------------------------------------------------------------------
package darkio_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [31:0] DARKIO_ERR_DATA = 32'hFFFF_FFFF;

  // Master i owns bits [32i+31:32i] of a 64-bit packed bus.
  function automatic logic [31:0] pick32(input logic [63:0] v, input logic sel);
    return sel ? v[63:32] : v[31:0];
  endfunction

  // Master i owns bits [4i+3:4i] of an 8-bit packed bus.
  function automatic logic [3:0] pick4(input logic [7:0] v, input logic sel);
    return sel ? v[7:4] : v[3:0];
  endfunction

endpackage

// File: rtl/darkio_arb_rr.sv
// -----------------------------------------------------------------------------
// darkio_arb_rr
// Two-way round-robin picker.
//   req_i  [1:0] : request vector, bit i = master i
//   last_i       : master that was granted most recently
//   sel_o        : master to grant; the sole requester, or the one that did
//                  not go last when both request
// Only meaningful when req_i != 0; the caller qualifies with |req_i.
// -----------------------------------------------------------------------------
module darkio_arb_rr (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       sel_o
);

  always_comb begin
    if (req_i == 2'b11) begin
      sel_o = ~last_i;
    end else begin
      sel_o = req_i[1];
    end
  end

endmodule

// File: rtl/darkio_arb.sv
// -----------------------------------------------------------------------------
// darkio_arb
// Round-robin arbiter sharing one darkio X-bus between master 0 (core data
// port) and master 1 (debug/DMA engine). One transaction at a time, one IDLE
// cycle between transactions, optional per-transaction watchdog.
//
// Ports
//   CLK, RES            clock, synchronous active-high reset
//   HLT                 blocks new grants (a running transaction finishes)
//   MDREQ/MWR/MRD [1:0] per-master request and strobes
//   MBE [7:0]           per-master byte enables, [4i+3:4i]
//   MADDR/MATAI [63:0]  per-master address / write data, [32i+31:32i]
//   MATAO [31:0]        read data, straight from darkio
//   MDACK/MERR [1:0]    per-master acknowledge / error (error valid with ack)
//   XDREQ/XWR/XRD/XBE/XADDR/XATAI  to darkio (all zero outside BUSY)
//   XATAO, XDACK        from darkio
//   GNT [1:0]           one-hot current grant (debug)
//
// Parameters
//   TMO_CYCLES  BUSY cycles without XDACK before an error completion; 0 = off
//   TMO_BITS    watchdog counter width, must hold TMO_CYCLES
// -----------------------------------------------------------------------------
module darkio_arb
  import darkio_arb_pkg::*;
#(
  parameter int TMO_CYCLES = 255,
  parameter int TMO_BITS   = 8
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        HLT,
  input  logic [1:0]  MDREQ,
  input  logic [1:0]  MWR,
  input  logic [1:0]  MRD,
  input  logic [7:0]  MBE,
  input  logic [63:0] MADDR,
  input  logic [63:0] MATAI,
  output logic [31:0] MATAO,
  output logic [1:0]  MDACK,
  output logic [1:0]  MERR,
  output logic        XDREQ,
  output logic        XWR,
  output logic        XRD,
  output logic [3:0]  XBE,
  output logic [31:0] XADDR,
  output logic [31:0] XATAI,
  input  logic [31:0] XATAO,
  input  logic        XDACK,
  output logic [1:0]  GNT
);

  localparam bit                  TMO_EN   = (TMO_CYCLES != 0);
  localparam logic [TMO_BITS-1:0] TMO_LAST =
    TMO_BITS'((TMO_CYCLES == 0) ? 0 : TMO_CYCLES - 1);

  state_e              state_q, state_d;
  logic                gsel_q,  gsel_d;
  logic                last_q,  last_d;
  logic [TMO_BITS-1:0] tmo_q,   tmo_d;

  logic rr_sel;
  logic req_g;
  logic timeout;

  darkio_arb_rr u_rr (
    .req_i  (MDREQ),
    .last_i (last_q),
    .sel_o  (rr_sel)
  );

  // Read data is never muxed: a master only looks at it under its own MDACK.
  assign MATAO = XATAO;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q <= ST_IDLE;
      gsel_q  <= 1'b0;
      last_q  <= 1'b1;   // master 0 wins the first contest after reset
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      gsel_q  <= gsel_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

  assign req_g   = MDREQ[gsel_q];
  // An XDACK in the expiry cycle wins: that transaction completes normally.
  // A dropped request is an abort, not a timeout.
  assign timeout = TMO_EN && (state_q == ST_BUSY) && (tmo_q == TMO_LAST)
                   && !XDACK && req_g;

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    gsel_d  = gsel_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    GNT     = 2'b00;
    MDACK   = 2'b00;
    MERR    = 2'b00;
    XDREQ   = 1'b0;
    XWR     = 1'b0;
    XRD     = 1'b0;
    XBE     = 4'h0;
    XADDR   = 32'h0;
    XATAI   = 32'h0;

    unique case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (!HLT && (MDREQ != 2'b00)) begin
          state_d = ST_BUSY;
          gsel_d  = rr_sel;
        end
      end

      ST_BUSY: begin
        GNT[gsel_q]   = 1'b1;
        XDREQ         = req_g && !timeout;
        XWR           = MWR[gsel_q];
        XRD           = MRD[gsel_q];
        XBE           = pick4(MBE, gsel_q);
        XADDR         = pick32(MADDR, gsel_q);
        XATAI         = pick32(MATAI, gsel_q);
        MDACK[gsel_q] = XDACK || timeout;
        MERR[gsel_q]  = timeout;

        if (XDACK || timeout || !req_g) begin
          state_d = ST_IDLE;
          last_d  = gsel_q;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs are held quiet during reset so a transaction cut off by RES
    // never produces an acknowledge or a strobe to darkio.
    if (RES) begin
      GNT   = 2'b00;
      MDACK = 2'b00;
      MERR  = 2'b00;
      XDREQ = 1'b0;
      XWR   = 1'b0;
      XRD   = 1'b0;
      XBE   = 4'h0;
      XADDR = 32'h0;
      XATAI = 32'h0;
    end
  end

endmodule
